// File: rtl/led_display_ctrl_pkg.sv
// Shared constants and types for the multiplexed 8-digit seven-segment display controller.
package led_display_ctrl_pkg;

    localparam int WordBus    = 32;
    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_MASK = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Everything that reaches the pins, kept together so the output stage is one register.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] en;
        logic [6:0]            seg;
        logic                  dp;
    } disp_t;

    localparam disp_t DISP_DARK = disp_t'({{NUM_DIGITS{1'b1}}, SEG_BLANK, 1'b1});

endpackage

// File: rtl/led_display_ctrl_seg7.sv
// Hex nibble to active-low seven-segment code, ordered {a,b,c,d,e,f,g}.
module seg7_hex_decode
    import led_display_ctrl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_display_ctrl.sv
// Register-mapped 8-digit multiplexed hex display: DATA/MASK registers, scan prescaler,
// digit index and a single registered output stage.
module led_display_ctrl
    import led_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen_i,
    input  logic               addr_i,
    input  logic [WordBus-1:0] wdata_i,
    output logic [WordBus-1:0] rdata_o,
    output logic [7:0]         led_en_o,
    output logic               led_ca_o,
    output logic               led_cb_o,
    output logic               led_cc_o,
    output logic               led_cd_o,
    output logic               led_ce_o,
    output logic               led_cf_o,
    output logic               led_cg_o,
    output logic               led_dp_o
);

    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WordBus-1:0]    data_q, data_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    disp_t                 disp_q, disp_d;

    logic                  tick;
    logic [3:0]            digit_nib;
    logic [6:0]            digit_seg;
    logic [NUM_DIGITS-1:0] en_dec;

    assign tick      = (cnt_q == CNT_LAST);
    assign digit_nib = data_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .hex_i (digit_nib),
        .seg_o (digit_seg)
    );

    // One-cold enable for the digit currently being scanned.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_en_dec
        assign en_dec[gi] = (idx_q != IDX_W'(gi));
    end

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = tick ? idx_q + 1'b1 : idx_q;
        data_d = data_q;
        mask_d = mask_q;
        if (wen_i) begin
            if (addr_i == REG_MASK) begin
                mask_d = wdata_i[NUM_DIGITS-1:0];
            end else begin
                data_d = wdata_i;
            end
        end

        // Outputs are built from the current registers, so a write shows up one edge after it lands.
        disp_d = DISP_DARK;
        if (mask_q[idx_q]) begin
            disp_d.en  = en_dec;
            disp_d.seg = digit_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            mask_q <= '1;
            disp_q <= DISP_DARK;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            mask_q <= mask_d;
            disp_q <= disp_d;
        end
    end

    always_comb begin
        rdata_o = data_q;
        if (addr_i == REG_MASK) begin
            rdata_o = {{(WordBus - NUM_DIGITS){1'b0}}, mask_q};
        end
    end

    assign led_en_o = disp_q.en;
    assign {led_ca_o, led_cb_o, led_cc_o, led_cd_o, led_ce_o, led_cf_o, led_cg_o} = disp_q.seg;
    assign led_dp_o = disp_q.dp;

endmodule
